// File: rtl/vga_timing_controller_if.sv
// Scan-out status bundle between the VGA timing sequencer and the pixel pipeline.
// The master drives the timing decode. The slave requests scan-out through enable.
interface vga_timing_controller_if #(
  parameter int COUNTER_SIZE = 11
);
  logic                    enable;
  logic                    running;
  logic                    pixel_tick;
  logic                    h_sync;
  logic                    v_sync;
  logic                    video_on;
  logic [COUNTER_SIZE-1:0] pixel_x;
  logic [COUNTER_SIZE-1:0] pixel_y;
  logic                    line_start;
  logic                    frame_start;

  modport master (
    input  enable,
    output running, pixel_tick, h_sync, v_sync, video_on,
           pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    output enable,
    input  running, pixel_tick, h_sync, v_sync, video_on,
           pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_controller.sv
// Frame-level VGA timing sequencer: pixel-tick divider, h/v position counters, sync/active decode.
// Scan-out starts and stops only on whole-frame boundaries.
module vga_timing_controller #(
  parameter int H_SYNC        = 96,
  parameter int H_BACK        = 48,
  parameter int H_ACTIVE      = 640,
  parameter int H_FRONT       = 16,
  parameter int V_SYNC        = 2,
  parameter int V_BACK        = 33,
  parameter int V_ACTIVE      = 480,
  parameter int V_FRONT       = 10,
  parameter int CLK_DIV       = 2,
  parameter bit SYNC_POLARITY = 1'b1,
  parameter int COUNTER_SIZE  = 11
) (
  input  logic                   control_clock,
  input  logic                   reset,
  vga_timing_controller_if.master tim
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef logic [COUNTER_SIZE-1:0] cnt_t;
  typedef logic [DIV_W-1:0]        div_t;

  localparam cnt_t CNT_ONE   = cnt_t'(1);
  localparam cnt_t H_LAST    = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST    = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_SYN_END = cnt_t'(H_SYNC);
  localparam cnt_t V_SYN_END = cnt_t'(V_SYNC);
  localparam cnt_t H_ACT_BEG = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t V_ACT_BEG = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t H_ACT_END = cnt_t'(H_SYNC + H_BACK + H_ACTIVE);
  localparam cnt_t V_ACT_END = cnt_t'(V_SYNC + V_BACK + V_ACTIVE);
  localparam div_t DIV_ONE   = div_t'(1);
  localparam div_t DIV_LAST  = div_t'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e state_q, state_d;
  cnt_t   h_q, h_d, v_q, v_d;
  div_t   div_q, div_d;
  logic   running_q, running_d;
  logic   pixel_tick_q, pixel_tick_d;
  logic   h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic   video_on_q, video_on_d;
  cnt_t   pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic   line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic   adv, frame_end, start;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can imply a latch.
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    div_d     = div_q;
    adv       = pixel_tick_q;
    frame_end = pixel_tick_q && (h_q == H_LAST) && (v_q == V_LAST);

    unique case (state_q)
      IDLE:    if (tim.enable) state_d = RUN;
      RUN:     if (!tim.enable) state_d = DRAIN;
      DRAIN:   if (tim.enable) state_d = RUN;
               else if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    start     = (state_q == IDLE) && (state_d == RUN);
    running_d = (state_d != IDLE);

    // Starting from IDLE and dropping back to IDLE both reload the origin.
    if (!running_d || start) begin
      h_d   = '0;
      v_d   = '0;
      div_d = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
      if (adv) begin
        if (h_q == H_LAST) begin
          h_d = '0;
          v_d = (v_q == V_LAST) ? '0 : v_q + CNT_ONE;
        end else begin
          h_d = h_q + CNT_ONE;
        end
      end
    end

    // Outputs decode the next counts so they land on the same edge as the counters.
    pixel_tick_d  = running_d && (div_d == DIV_LAST);
    line_start_d  = start || (running_d && adv && (h_q == H_LAST));
    frame_start_d = start || (running_d && frame_end);
    h_sync_d      = (running_d && (h_d < H_SYN_END)) ? SYNC_POLARITY : ~SYNC_POLARITY;
    v_sync_d      = (running_d && (v_d < V_SYN_END)) ? SYNC_POLARITY : ~SYNC_POLARITY;
    video_on_d    = running_d && (h_d >= H_ACT_BEG) && (h_d < H_ACT_END)
                              && (v_d >= V_ACT_BEG) && (v_d < V_ACT_END);
    pixel_x_d     = video_on_d ? (h_d - H_ACT_BEG) : '0;
    pixel_y_d     = video_on_d ? (v_d - V_ACT_BEG) : '0;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge control_clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      div_q         <= '0;
      running_q     <= 1'b0;
      pixel_tick_q  <= 1'b0;
      h_sync_q      <= ~SYNC_POLARITY;
      v_sync_q      <= ~SYNC_POLARITY;
      video_on_q    <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      div_q         <= div_d;
      running_q     <= running_d;
      pixel_tick_q  <= pixel_tick_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign tim.running     = running_q;
  assign tim.pixel_tick  = pixel_tick_q;
  assign tim.h_sync      = h_sync_q;
  assign tim.v_sync      = v_sync_q;
  assign tim.video_on    = video_on_q;
  assign tim.pixel_x     = pixel_x_q;
  assign tim.pixel_y     = pixel_y_q;
  assign tim.line_start  = line_start_q;
  assign tim.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller on a shrunken raster: a frame-index model feeds a per-cycle
// scoreboard for two instances (CLK_DIV=2 active-high syncs, CLK_DIV=1 active-low syncs).
module tb_vga_timing_controller;

  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;   // 17
  localparam int VT = VS + VB + VA + VF;   // 9
  localparam int FRAME = HT * VT;          // 153 pixel ticks
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vga_timing_controller_if #(.COUNTER_SIZE(CW)) ifa ();
  vga_timing_controller_if #(.COUNTER_SIZE(CW)) ifb ();

  vga_timing_controller #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .CLK_DIV(2), .SYNC_POLARITY(1'b1), .COUNTER_SIZE(CW)
  ) dut_a (.control_clock(clk), .reset(rst), .tim(ifa));

  vga_timing_controller #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .CLK_DIV(1), .SYNC_POLARITY(1'b0), .COUNTER_SIZE(CW)
  ) dut_b (.control_clock(clk), .reset(rst), .tim(ifb));

  typedef struct packed {
    logic          running;
    logic          pixel_tick;
    logic          h_sync;
    logic          v_sync;
    logic          video_on;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;
  } obs_t;

  // st: 0 idle, 1 run, 2 drain; pos is the linear pixel index within the frame.
  typedef struct {
    int st;
    int div;
    int pos;
    bit ls;
    bit fs;
  } mdl_t;

  localparam mdl_t IDLE_M = '{st: 0, div: 0, pos: 0, ls: 1'b0, fs: 1'b0};

  mdl_t ma = IDLE_M;
  mdl_t mb = IDLE_M;
  obs_t qa[$];
  obs_t qb[$];
  obs_t ga, ea, gb, eb;
  int passes = 0;
  int total = 0;
  int cyc = 0;

  function automatic mdl_t mdl_next(mdl_t s, bit en, int cdiv);
    mdl_t n = s;
    bit adv, last;
    n.ls = 1'b0;
    n.fs = 1'b0;
    adv  = (s.st != 0) && (s.div == cdiv - 1);
    if (s.st == 0) begin
      if (en) begin
        n.st = 1; n.div = 0; n.pos = 0; n.ls = 1'b1; n.fs = 1'b1;
      end
    end else begin
      last  = adv && (s.pos == FRAME - 1);
      n.div = (s.div + 1) % cdiv;
      if (adv) begin
        n.pos = (s.pos + 1) % FRAME;
        n.ls  = (n.pos % HT == 0);
        n.fs  = (n.pos == 0);
      end
      if (s.st == 1 && !en) n.st = 2;
      else if (s.st == 2 && en) n.st = 1;
      else if (s.st == 2 && last) n = IDLE_M;
    end
    return n;
  endfunction

  function automatic obs_t mdl_out(mdl_t s, int cdiv, bit pol);
    obs_t o;
    int h = s.pos % HT;
    int v = s.pos / HT;
    bit run = (s.st != 0);
    o.running     = run;
    o.pixel_tick  = run && (s.div == cdiv - 1);
    o.h_sync      = (run && h < HS) ? pol : ~pol;
    o.v_sync      = (run && v < VS) ? pol : ~pol;
    o.video_on    = run && (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
    o.pixel_x     = o.video_on ? CW'(h - HST) : '0;
    o.pixel_y     = o.video_on ? CW'(v - VST) : '0;
    o.line_start  = s.ls;
    o.frame_start = s.fs;
    return o;
  endfunction

  function automatic obs_t sample(input bit which_b);
    obs_t o;
    if (!which_b) begin
      o = {ifa.running, ifa.pixel_tick, ifa.h_sync, ifa.v_sync, ifa.video_on,
           ifa.pixel_x, ifa.pixel_y, ifa.line_start, ifa.frame_start};
    end else begin
      o = {ifb.running, ifb.pixel_tick, ifb.h_sync, ifb.v_sync, ifb.video_on,
           ifb.pixel_x, ifb.pixel_y, ifb.line_start, ifb.frame_start};
    end
    return o;
  endfunction

  // Advance one clock: push the model's post-edge outputs, then land on the next falling edge.
  task automatic step();
    ma = mdl_next(ma, ifa.enable, 2);
    qa.push_back(mdl_out(ma, 2, 1'b1));
    mb = mdl_next(mb, ifb.enable, 1);
    qb.push_back(mdl_out(mb, 1, 1'b0));
    @(posedge clk);
    @(negedge clk);
    cyc++;
    ga = sample(1'b0);
    gb = sample(1'b1);
    ea = qa.pop_front();
    eb = qb.pop_front();
  endtask

  task automatic test_reset();
    obs_t idle_a, idle_b;
    idle_a = '0;
    idle_b = '0;
    idle_b.h_sync = 1'b1;
    idle_b.v_sync = 1'b1;
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    #1 rst = 1'b1;
    #2;
    total++;
    if (sample(1'b0) !== idle_a) $display("FAIL reset_a got=%h exp=%h", sample(1'b0), idle_a);
    else passes++;
    total++;
    if (sample(1'b1) !== idle_b) $display("FAIL reset_b got=%h exp=%h", sample(1'b1), idle_b);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (ga !== ea) $display("FAIL idle_a cyc=%0d got=%h exp=%h", cyc, ga, ea); else passes++;
      total++;
      if (gb !== eb) $display("FAIL idle_b cyc=%0d got=%h exp=%h", cyc, gb, eb); else passes++;
    end
  endtask

  task automatic test_frame();
    int fs_a = 0, fs_b = 0, first_a = -1, per_a = -1, first_b = -1, per_b = -1;
    int hs_n = 0, vs_n = 0, vo_n = 0, px_n = 0, sum_x = 0, sum_y = 0;
    ifa.enable = 1'b1;
    ifb.enable = 1'b1;
    for (int i = 0; i < 2 * 2 * FRAME + 20; i++) begin
      step();
      total++;
      if (ga !== ea) $display("FAIL frame_a cyc=%0d got=%h exp=%h", cyc, ga, ea); else passes++;
      total++;
      if (gb !== eb) $display("FAIL frame_b cyc=%0d got=%h exp=%h", cyc, gb, eb); else passes++;
      if (ga.frame_start) begin
        fs_a++;
        if (fs_a == 1) first_a = cyc;
        if (fs_a == 2) per_a = cyc - first_a;
      end
      if (gb.frame_start) begin
        fs_b++;
        if (fs_b == 1) first_b = cyc;
        if (fs_b == 2) per_b = cyc - first_b;
      end
      if (fs_a == 1) begin
        hs_n += int'(ga.h_sync);
        vs_n += int'(ga.v_sync);
        vo_n += int'(ga.video_on);
        if (ga.video_on && ga.pixel_tick) begin
          px_n++;
          sum_x += int'(ga.pixel_x);
          sum_y += int'(ga.pixel_y);
        end
      end
    end
    total++; if (per_a !== 2 * FRAME) $display("FAIL frame_period_a got=%0d exp=%0d", per_a, 2 * FRAME); else passes++;
    total++; if (per_b !== FRAME) $display("FAIL frame_period_b got=%0d exp=%0d", per_b, FRAME); else passes++;
    total++; if (hs_n !== 2 * HS * VT) $display("FAIL hsync_clocks got=%0d exp=%0d", hs_n, 2 * HS * VT); else passes++;
    total++; if (vs_n !== 2 * VS * HT) $display("FAIL vsync_clocks got=%0d exp=%0d", vs_n, 2 * VS * HT); else passes++;
    total++; if (vo_n !== 2 * HA * VA) $display("FAIL video_clocks got=%0d exp=%0d", vo_n, 2 * HA * VA); else passes++;
    total++; if (px_n !== HA * VA) $display("FAIL pixel_count got=%0d exp=%0d", px_n, HA * VA); else passes++;
    total++; if (sum_x !== VA * HA * (HA - 1) / 2) $display("FAIL pixel_x_sum got=%0d exp=%0d", sum_x, VA * HA * (HA - 1) / 2); else passes++;
    total++; if (sum_y !== HA * VA * (VA - 1) / 2) $display("FAIL pixel_y_sum got=%0d exp=%0d", sum_y, HA * VA * (VA - 1) / 2); else passes++;
  endtask

  task automatic test_drain();
    int budget, fs_after = 0;
    budget = 4 * FRAME;
    while (ma.pos / HT != 2 && budget > 0) begin
      step();
      budget--;
      total++;
      if (ga !== ea) $display("FAIL pre_drain_a cyc=%0d got=%h exp=%h", cyc, ga, ea); else passes++;
    end
    ifa.enable = 1'b0;
    ifb.enable = 1'b0;
    budget = 4 * FRAME;
    while ((ma.st != 0 || mb.st != 0) && budget > 0) begin
      step();
      budget--;
      fs_after += int'(ga.frame_start);
      total++;
      if (ga !== ea) $display("FAIL drain_a cyc=%0d got=%h exp=%h", cyc, ga, ea); else passes++;
      total++;
      if (gb !== eb) $display("FAIL drain_b cyc=%0d got=%h exp=%h", cyc, gb, eb); else passes++;
    end
    total++;
    if (budget == 0) $display("FAIL drain_timeout got=%0d exp=0", ma.st); else passes++;
    for (int i = 0; i < 6; i++) begin
      step();
      fs_after += int'(ga.frame_start);
      total++;
      if (ga !== ea) $display("FAIL post_drain_a cyc=%0d got=%h exp=%h", cyc, ga, ea); else passes++;
    end
    total++;
    if (fs_after !== 0) $display("FAIL drain_frame_start got=%0d exp=0", fs_after); else passes++;
    total++;
    if (ifa.running !== 1'b0 || ifa.h_sync !== 1'b0 || ifb.h_sync !== 1'b1)
      $display("FAIL drain_idle got=%b%b%b exp=001", ifa.running, ifa.h_sync, ifb.h_sync);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int fs_n = 0, first = -1, per = -1, low_n = 0;
    ifa.enable = 1'b1;
    ifb.enable = 1'b1;
    for (int i = 0; i < 2 * FRAME + 40; i++) begin
      if (i == 100) ifa.enable = 1'b0;
      if (i == 130) ifa.enable = 1'b1;
      step();
      total++;
      if (ga !== ea) $display("FAIL reenable_a cyc=%0d got=%h exp=%h", cyc, ga, ea); else passes++;
      if (!ga.running) low_n++;
      if (ga.frame_start) begin
        fs_n++;
        if (fs_n == 1) first = cyc;
        if (fs_n == 2) per = cyc - first;
      end
    end
    total++; if (per !== 2 * FRAME) $display("FAIL reenable_period got=%0d exp=%0d", per, 2 * FRAME); else passes++;
    total++; if (low_n !== 0) $display("FAIL reenable_running got=%0d exp=0", low_n); else passes++;
  endtask

  task automatic test_async_reset();
    int budget = 4 * FRAME;
    obs_t idle_a, idle_b;
    idle_a = '0;
    idle_b = '0;
    idle_b.h_sync = 1'b1;
    idle_b.v_sync = 1'b1;
    while (!mdl_out(ma, 2, 1'b1).video_on && budget > 0) begin
      step();
      budget--;
    end
    total++;
    if (ifa.video_on !== 1'b1) $display("FAIL mid_active got=%b exp=1", ifa.video_on); else passes++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (sample(1'b0) !== idle_a) $display("FAIL async_reset_a got=%h exp=%h", sample(1'b0), idle_a); else passes++;
    total++;
    if (sample(1'b1) !== idle_b) $display("FAIL async_reset_b got=%h exp=%h", sample(1'b1), idle_b); else passes++;
    ma = IDLE_M;
    mb = IDLE_M;
    @(negedge clk);
    rst = 1'b0;
    step();
    total++;
    if (ga.frame_start !== 1'b1 || ga.pixel_x !== '0 || ga.h_sync !== 1'b1)
      $display("FAIL restart_a got=%h exp=frame_start at origin", ga);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (ga !== ea) $display("FAIL restart_a cyc=%0d got=%h exp=%h", cyc, ga, ea); else passes++;
      total++;
      if (gb !== eb) $display("FAIL restart_b cyc=%0d got=%h exp=%h", cyc, gb, eb); else passes++;
      step();
    end
  endtask

  task automatic test_clk_div1();
    int ticks = 0, ls_n = 0, first = -1, per = -1, hs_n = 0;
    for (int i = 0; i < 3 * HT; i++) begin
      step();
      total++;
      if (gb !== eb) $display("FAIL div1_b cyc=%0d got=%h exp=%h", cyc, gb, eb); else passes++;
      ticks += int'(gb.pixel_tick);
      if (gb.line_start) begin
        ls_n++;
        if (ls_n == 1) first = cyc;
        if (ls_n == 2) per = cyc - first;
      end
      if (ls_n == 1 && gb.h_sync == 1'b0) hs_n++;
    end
    total++; if (ticks !== 3 * HT) $display("FAIL div1_ticks got=%0d exp=%0d", ticks, 3 * HT); else passes++;
    total++; if (per !== HT) $display("FAIL div1_line_period got=%0d exp=%0d", per, HT); else passes++;
    total++; if (hs_n !== HS) $display("FAIL div1_hsync got=%0d exp=%0d", hs_n, HS); else passes++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_drain();
    test_back_to_back();
    test_async_reset();
    test_clk_div1();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
